// File: rtl/uart_tx_serialiser_if.sv
// rtl/uart_tx_serialiser_if.sv - producer handshake and serial-line bundle for the UART transmitter
interface uart_tx_serialiser_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] TX_DATA;
  logic                  TX_VALID;
  logic                  TX_READY;
  logic                  TX_SERIAL;
  logic                  TX_BUSY;
  logic                  TX_DONE;

  modport master (
    output TX_DATA, TX_VALID,
    input  TX_READY, TX_SERIAL, TX_BUSY, TX_DONE
  );

  modport slave (
    input  TX_DATA, TX_VALID,
    output TX_READY, TX_SERIAL, TX_BUSY, TX_DONE
  );
endinterface

// File: rtl/uart_tx_serialiser.sv
// rtl/uart_tx_serialiser.sv - start/data(LSB first)/stop UART transmitter with valid/ready intake
// Outputs are registered from the next state so the line changes on the edge after the handshake.
module uart_tx_serialiser #(
  parameter int CLKS_PER_BIT = 100,
  parameter int DATA_WIDTH   = 8
) (
  input logic                 CLK,
  input logic                 RESET,
  uart_tx_serialiser_if.slave tx
);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_WIDTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  serial_q, serial_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // ready_q gates intake so the first edge out of reset never accepts a word
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (tx.TX_VALID && ready_q) begin
          shift_d = tx.TX_DATA;
          state_d = START;
        end
      end
      START: begin
        baud_d = baud_end ? '0 : baud_q + BAUD_W'(1);
        if (baud_end) state_d = DATA;
      end
      DATA: begin
        baud_d = baud_end ? '0 : baud_q + BAUD_W'(1);
        if (baud_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      STOP: begin
        baud_d = baud_end ? '0 : baud_q + BAUD_W'(1);
        if (baud_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    serial_d = 1'b1;
    ready_d  = 1'b0;
    busy_d   = 1'b1;
    case (state_d)
      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[0];
      default: serial_d = 1'b1;
    endcase
    done_d = (state_q == STOP) && (state_d == IDLE);
  end

  assign tx.TX_SERIAL = serial_q;
  assign tx.TX_READY  = ready_q;
  assign tx.TX_BUSY   = busy_q;
  assign tx.TX_DONE   = done_q;
endmodule
